seg7_scan_driver: RTL
=====================

# seg7_scan_driver

Time-multiplexed driver for the board's 4-digit common-anode seven-segment display. It sits directly downstream of the register-bank/ALU FPGA wrapper and consumes that wrapper's 16-bit `out` word, rendering it as four hex digits. A shadow register samples the input once per scan frame, so a value changing mid-frame never produces a mixed display. A guard gap at the start of each digit slot suppresses ghosting.

## Interface
- `DIV`, default 100000: clock cycles per digit slot; legal range ≥ 4.
- `GUARD`, default 16: cycles at the start of each slot with all anodes off; legal range 1 ≤ GUARD < DIV.
- `clk` input, 1 bit: system clock; all state updates on the rising edge.
- `reset` input, 1 bit: synchronous, active-high.
- `value` input, 16 bits: word to display; bits [3:0] are the rightmost digit.
- `dp_in` input, 4 bits: per-digit decimal-point request, 1 = lit; bit k belongs to digit k.
- `en` input, 1 bit: display enable; 0 forces every anode off while counters keep running.
- `an` output, 4 bits: anode selects, active-low; `an[0]` is the rightmost digit.
- `seg` output, 7 bits: cathodes `{g,f,e,d,c,b,a}`, active-low.
- `dp` output, 1 bit: decimal-point cathode, active-low.

## Operation
- `cnt` counts from 0 to DIV-1 and wraps. The wrap cycle, where `cnt == DIV-1`, is the slot terminal.
- `idx` (2 bits) advances on each slot terminal in the order 0→1→2→3→0.
- Frame boundary: the slot terminal with `idx == 3`. On that edge, `value` and `dp_in` load into `shadow` and `dp_shadow`.
- Outputs during digit slot k:
  - `seg` = hex pattern of `shadow[4k+3:4k]`.
  - `dp` = `~dp_shadow[k]`.
  - `an` = all ones except bit k, which is 0.
- Forced-off conditions: whenever `cnt < GUARD` or `en == 0`, `an` is `4'b1111`. `seg` and `dp` keep their slot value under these conditions.
- Hex encoding, active-low:
  - 0 = `1000000`, 1 = `1111001`, 2 = `0100100`, 3 = `0110000`
  - 4 = `0011001`, 5 = `0010010`, 6 = `0000010`, 7 = `1111000`
  - 8 = `0000000`, 9 = `0010000`, A = `0001000`, b = `0000011`
  - C = `1000110`, d = `0100001`, E = `0000110`, F = `0001110`
- Reset sets `cnt = 0`, `idx = 0`, `shadow = 0`, `dp_shadow = 0`, `an = 4'b1111`, `seg = 7'b1111111`, `dp = 1`.
- The first frame after reset therefore shows `0000`. The first `value` is taken at the end of that first frame.
- Reset asserted mid-frame takes effect on the next edge: the scan restarts at slot 0 and `shadow` clears.

## Timing
- `an`, `seg` and `dp` are registered from `cnt`, `idx` and `shadow`, giving exactly 1 cycle of latency. All three change on the same edge, with no combinational output path.
- Slot length is DIV cycles; frame length is 4·DIV cycles.
- In each slot, the selected anode is low for DIV−GUARD cycles, from registered `cnt == GUARD` through `DIV-1`, delayed one clock.
- Latency from a `value` change to the display: at most 4·DIV+1 cycles. A change that arrives on the frame-boundary edge itself is captured.
- `en` deassert blanks the display 1 cycle later. `en` reassert resumes at the current scan position; there is no restart.

## Configuration
- `SEG7_LZ_BLANK_EN` defined: leading-zero blanking.
  - Digit k (for k = 3, 2, 1) is blanked when `shadow[15:4k]` is entirely zero.
  - A blanked digit drives `seg = 7'b1111111` and keeps its anode high for the whole slot.
  - Exception: if `dp_shadow[k]` is set, the digit is not blanked (anode driven, `seg = 7'b1111111`, `dp` lit).
  - Digit 0 is never blanked.
- `SEG7_LZ_BLANK_EN` undefined: all four digits are always displayed, including leading zeros.

## Structure
- Package `seg7_pkg`:
  - `NUM_DIGITS = 4`
  - `SEG_BLANK = 7'b1111111`
  - the 16-entry hex-to-segment constant table
  - typedef `seg_t` (7-bit) and `digit_idx_t` (2-bit)
- One combinational sub-module `seg7_hex_decode` (nibble in, `seg_t` out), instantiated once on the muxed nibble.
- Counter, index, shadow logic and output registers live in `seg7_scan_driver`.

## Test plan
All scenarios use DIV=8 and GUARD=2.
- Reset, then release with `value = 16'h1234`, `en = 1`:
  - First frame shows `0000`: `seg = 1000000` in every slot, anodes cycling 1110→1101→1011→0111.
  - Second frame shows `an = 1110` with `seg = 0011001` ('4'), then `an = 1101` with `seg = 0110000` ('3'), and so on.
- Guard check: in each slot, `an == 4'b1111` for exactly 2 cycles, then one anode low for 6 cycles. Never two anodes low at once.
- `value` changes from `16'hABCD` to `16'h0000` at the midpoint of slot 2: the rest of the frame still shows `A`/`B` digits, and the next frame shows zeros.
- `en` driven 0 for 10 cycles mid-slot: `an = 4'b1111` from the next cycle; the scan position after re-enable matches an uninterrupted reference counter.
- With `SEG7_LZ_BLANK_EN` and `value = 16'h00F0`:
  - Digits 3 and 2 have their anode held high for the whole slot.
  - Digit 1 shows `0001110` ('F').
  - Digit 0 shows `1000000` ('0').
- `dp_in = 4'b0100`, `value = 16'h0001`, with `SEG7_LZ_BLANK_EN`: digit 2 is driven with `seg = 1111111` and `dp = 0`; digit 3 is blanked.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// Segment patterns are active-low and ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

   localparam int NUM_DIGITS = 4;

   typedef logic [6:0] seg_t;
   typedef logic [1:0] digit_idx_t;

   localparam seg_t SEG_BLANK = 7'b1111111;

   localparam seg_t HEX_TABLE [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Display-side bundle: the word to show, its decimal points and enable,
// plus the multiplexed anode/cathode drive coming back from the scanner.
interface seg7_scan_driver_if;
   import seg7_pkg::*;

   logic [15:0] value;
   logic [3:0]  dp_in;
   logic        en;
   logic [3:0]  an;
   seg_t        seg;
   logic        dp;

   modport master (output value, dp_in, en, input an, seg, dp);
   modport slave  (input value, dp_in, en, output an, seg, dp);
endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-low seven-segment pattern lookup.
module seg7_hex_decode
   import seg7_pkg::*;
(
   input  logic [3:0] nibble,
   output seg_t       seg
);

   always_comb begin
      seg = HEX_TABLE[nibble];
   end

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed seven-segment driver with per-frame shadow capture
// and a blank guard at the start of every slot. SEG7_LZ_BLANK_EN enables
// leading-zero blanking.
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int DIV   = 100000,
   parameter int GUARD = 16
) (
   input  logic                clk,
   input  logic                reset,
   seg7_scan_driver_if.slave   bus
);

   localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

   logic [CW-1:0]         cnt_reg, cnt_next;
   digit_idx_t            idx_reg, idx_next;
   logic [15:0]           shadow_reg, shadow_next;
   logic [NUM_DIGITS-1:0] dp_shadow_reg, dp_shadow_next;
   logic [3:0]            an_reg, an_next;
   seg_t                  seg_reg, seg_next;
   logic                  dp_reg, dp_next;

   logic                  slot_terminal;
   logic                  frame_end;
   logic [3:0]            nibble;
   seg_t                  hex_seg;
   logic                  sel_dp;
   logic                  zero_lead;

   assign nibble = 4'(shadow_reg >> {idx_reg, 2'b00});

   seg7_hex_decode u_hex (
      .nibble (nibble),
      .seg    (hex_seg)
   );

`ifdef SEG7_LZ_BLANK_EN
   // A digit is a leading zero when it and every digit to its left are zero.
   logic [NUM_DIGITS-1:0] lead_zero;
   genvar gi;
   generate
      for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
         if (gi == 0) begin : g_units
            assign lead_zero[gi] = 1'b0;
         end else begin : g_upper
            assign lead_zero[gi] = (shadow_reg[15:4*gi] == '0);
         end
      end
   endgenerate
   assign zero_lead = lead_zero[idx_reg];
`else
   assign zero_lead = 1'b0;
`endif

   always_comb begin
      slot_terminal  = (cnt_reg == CW'(DIV - 1));
      frame_end      = slot_terminal && (idx_reg == digit_idx_t'(NUM_DIGITS - 1));
      cnt_next       = slot_terminal ? '0 : cnt_reg + 1'b1;
      idx_next       = slot_terminal ? idx_reg + 2'd1 : idx_reg;
      shadow_next    = frame_end ? bus.value : shadow_reg;
      dp_shadow_next = frame_end ? bus.dp_in : dp_shadow_reg;

      sel_dp   = dp_shadow_reg[idx_reg];
      seg_next = zero_lead ? SEG_BLANK : hex_seg;
      dp_next  = ~sel_dp;
      an_next  = 4'b1111;
      // A zero-blanked digit still lights its anode so a requested point shows.
      if (bus.en && (cnt_reg >= CW'(GUARD)) && (!zero_lead || sel_dp)) begin
         an_next = ~(4'b0001 << idx_reg);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_reg       <= '0;
         idx_reg       <= '0;
         shadow_reg    <= '0;
         dp_shadow_reg <= '0;
         an_reg        <= 4'b1111;
         seg_reg       <= SEG_BLANK;
         dp_reg        <= 1'b1;
      end else begin
         cnt_reg       <= cnt_next;
         idx_reg       <= idx_next;
         shadow_reg    <= shadow_next;
         dp_shadow_reg <= dp_shadow_next;
         an_reg        <= an_next;
         seg_reg       <= seg_next;
         dp_reg        <= dp_next;
      end
   end

   assign bus.an  = an_reg;
   assign bus.seg = seg_reg;
   assign bus.dp  = dp_reg;

endmodule
